// File: rtl/segre_pkg.sv
// Shared types and sizes for the segre core pipeline.
package segre_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;
    localparam int REG_SIZE  = 5;
    localparam int DMEM_BE_W = 4;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } memop_data_type_e;

    typedef logic [1:0] mem_state_e;
    localparam mem_state_e IDLE = 2'd0;
    localparam mem_state_e REQ  = 2'd1;
    localparam mem_state_e WAIT = 2'd2;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic                 we;
        logic [DMEM_BE_W-1:0] be;
        logic [WORD_SIZE-1:0] wdata;
    } dmem_req_t;

    function automatic logic is_misaligned(input memop_data_type_e memop_type,
                                           input logic [1:0]       addr_lsb);
        case (memop_type)
            HALF:    return addr_lsb[0];
            WORD:    return addr_lsb != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/segre_lsu_fmt.sv
// Combinational lane formatting: store byte enables/data, load extraction and
// extension, and misalignment detection.
module segre_lsu_fmt
    import segre_pkg::*;
(
    input  memop_data_type_e       memop_type,
    input  logic [1:0]             addr_lsb,
    input  logic [WORD_SIZE-1:0]   st_data,
    input  logic [WORD_SIZE-1:0]   ld_rdata,
    input  logic                   sign_ext,
    output logic [DMEM_BE_W-1:0]   be,
    output logic [WORD_SIZE-1:0]   wdata,
    output logic [WORD_SIZE-1:0]   ld_data,
    output logic                   misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte    = ld_rdata[{addr_lsb, 3'b000} +: 8];
    assign ld_half    = ld_rdata[{addr_lsb[1], 4'b0000} +: 16];
    assign misaligned = is_misaligned(memop_type, addr_lsb);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be      = '0;
        wdata   = '0;
        ld_data = '0;
        case (memop_type)
            BYTE: begin
                be      = 4'b0001 << addr_lsb;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            end
            HALF: begin
                be      = 4'b0011 << addr_lsb;
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
            end
            default: begin
                be      = 4'b1111;
                wdata   = st_data;
                ld_data = ld_rdata;
            end
        endcase
    end

endmodule

// File: rtl/segre_mem_stage.sv
// MEM pipeline stage: data-memory access FSM, upstream stall and the MEM/WB
// output registers.
module segre_mem_stage
    import segre_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic [WORD_SIZE-1:0]   alu_res_i,
    input  logic                   rf_we_i,
    input  logic [REG_SIZE-1:0]    rf_waddr_i,
    input  logic [WORD_SIZE-1:0]   rf_st_data_i,
    input  memop_data_type_e       memop_type_i,
    input  logic                   memop_rd_i,
    input  logic                   memop_wr_i,
    input  logic                   memop_sign_ext_i,
    input  logic                   tkbr_i,
    input  logic [ADDR_SIZE-1:0]   new_pc_i,
    input  logic [ADDR_SIZE-1:0]   seq_new_pc_i,
    input  logic                   is_jaljalr_i,
    output logic                   stall_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [ADDR_SIZE-1:0]   dmem_addr_o,
    output logic [DMEM_BE_W-1:0]   dmem_be_o,
    output logic [WORD_SIZE-1:0]   dmem_wdata_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [WORD_SIZE-1:0]   dmem_rdata_i,
    output logic                   rf_we_o,
    output logic [REG_SIZE-1:0]    rf_waddr_o,
    output logic [WORD_SIZE-1:0]   rf_wdata_o,
    output logic                   misaligned_o,
    output logic                   tkbr_o,
    output logic [ADDR_SIZE-1:0]   new_pc_o
);

    mem_state_e             state_q, state_d;
    dmem_req_t              cap_q, cur_req, out_req;
    logic [DMEM_BE_W-1:0]   fmt_be;
    logic [WORD_SIZE-1:0]   fmt_wdata, ld_data;
    logic                   fmt_mis, memop, is_store, mis, valid_op;
    logic                   busy, done, req, advance;

    segre_lsu_fmt u_fmt (
        .memop_type (memop_type_i),
        .addr_lsb   (alu_res_i[1:0]),
        .st_data    (rf_st_data_i),
        .ld_rdata   (dmem_rdata_i),
        .sign_ext   (memop_sign_ext_i),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .ld_data    (ld_data),
        .misaligned (fmt_mis)
    );

    // A load wins when both rd and wr are set, so no write is ever issued then.
    assign memop    = memop_rd_i | memop_wr_i;
    assign is_store = memop_wr_i & ~memop_rd_i;
    assign mis      = ALIGN_CHECK & memop & fmt_mis;
    assign valid_op = memop & ~mis;

    assign cur_req = '{addr:  {alu_res_i[ADDR_SIZE-1:2], 2'b00},
                       we:    is_store,
                       be:    fmt_be,
                       wdata: fmt_wdata};

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        req     = 1'b0;
        out_req = cur_req;
        case (state_q)
            IDLE: begin
                busy = valid_op;
                req  = valid_op;
                if (valid_op) begin
                    if (!dmem_gnt_i)   state_d = REQ;
                    else if (is_store) done    = 1'b1;
                    else               state_d = WAIT;
                end
            end
            REQ: begin
                // Hold the request from the captured copy until the memory accepts it.
                busy    = 1'b1;
                req     = 1'b1;
                out_req = cap_q;
                if (dmem_gnt_i) begin
                    if (cap_q.we) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (dmem_rvalid_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_req_o   = req & ~rsn_i;
    assign dmem_we_o    = out_req.we;
    assign dmem_addr_o  = out_req.addr;
    assign dmem_be_o    = out_req.be;
    assign dmem_wdata_o = out_req.wdata;
    assign stall_o      = busy & ~done & ~rsn_i;
    assign advance      = ~stall_o;

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rsn_i) begin
            state_q      <= IDLE;
            cap_q        <= '0;
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= '0;
            rf_wdata_o   <= '0;
            misaligned_o <= 1'b0;
            tkbr_o       <= 1'b0;
            new_pc_o     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && valid_op) cap_q <= cur_req;
            rf_we_o      <= advance & rf_we_i & ~mis;
            rf_waddr_o   <= rf_waddr_i;
            rf_wdata_o   <= memop_rd_i   ? ld_data      :
                            is_jaljalr_i ? seq_new_pc_i : alu_res_i;
            misaligned_o <= mis & (state_q == IDLE);
            tkbr_o       <= advance & tkbr_i;
            new_pc_o     <= new_pc_i;
        end
    end

endmodule

// File: tb/tb_segre_mem_stage.sv
// Self-checking bench for segre_mem_stage: transaction-level model plus directed vectors.
module tb_segre_mem_stage;
    import segre_pkg::*;

    logic             clk_i = 1'b0;
    logic             rsn_i;
    logic [31:0]      alu_res_i, rf_st_data_i, new_pc_i, seq_new_pc_i, dmem_rdata_i;
    logic             rf_we_i, memop_rd_i, memop_wr_i, memop_sign_ext_i, tkbr_i, is_jaljalr_i;
    logic [4:0]       rf_waddr_i;
    memop_data_type_e memop_type_i;
    logic             dmem_gnt_i, dmem_rvalid_i;
    logic             stall_o, dmem_req_o, dmem_we_o, rf_we_o, misaligned_o, tkbr_o;
    logic [31:0]      dmem_addr_o, dmem_wdata_o, rf_wdata_o, new_pc_o;
    logic [3:0]       dmem_be_o;
    logic [4:0]       rf_waddr_o;

    int n_checks = 0;
    int n_errors = 0;

    segre_mem_stage dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .alu_res_i(alu_res_i), .rf_we_i(rf_we_i),
        .rf_waddr_i(rf_waddr_i), .rf_st_data_i(rf_st_data_i), .memop_type_i(memop_type_i),
        .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i), .memop_sign_ext_i(memop_sign_ext_i),
        .tkbr_i(tkbr_i), .new_pc_i(new_pc_i), .seq_new_pc_i(seq_new_pc_i),
        .is_jaljalr_i(is_jaljalr_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .misaligned_o(misaligned_o), .tkbr_o(tkbr_o),
        .new_pc_o(new_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference rules written from the lane arithmetic, not from the RTL structure.
    function automatic logic [31:0] m_load(input memop_data_type_e t, input bit sx,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        case (t)
            BYTE: begin
                v = (rd >> (8 * (a % 4))) & 32'hFF;
                if (sx && v >= 32'h80) v = v - 32'h100;
            end
            HALF: begin
                v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
                if (sx && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_be(input memop_data_type_e t, input logic [31:0] a);
        case (t)
            BYTE:    return (32'd1 << (a % 4)) & 32'hF;
            HALF:    return (32'd3 << (a % 4)) & 32'hF;
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input memop_data_type_e t, input logic [31:0] d);
        case (t)
            BYTE:    return (d & 32'hFF) * 32'h01010101;
            HALF:    return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    // Model state: m_wait = a granted load still owes its data.
    bit          m_wait = 0, n_wait = 0;
    bit          e_we = 0, e_mis = 0, e_tk = 0, n_we = 0, n_mis = 0, n_tk = 0;
    logic [31:0] e_wdata = 0, e_pc = 0, n_wdata = 0, n_pc = 0;
    logic [4:0]  e_waddr = 0, n_waddr = 0;

    always @(negedge clk_i) begin : compare
        bit mis, store, done, stall, req;
        mis   = (memop_rd_i || memop_wr_i) &&
                ((memop_type_i == HALF && alu_res_i % 2 != 0) ||
                 (memop_type_i == WORD && alu_res_i % 4 != 0));
        store = memop_wr_i && !memop_rd_i;
        req   = 0;
        done  = 0;
        stall = 0;
        if (rsn_i) begin
            n_wait = 0;
        end else if (m_wait) begin
            done   = dmem_rvalid_i;
            stall  = !done;
            n_wait = !done;
        end else if ((memop_rd_i || memop_wr_i) && !mis) begin
            req    = 1;
            done   = dmem_gnt_i && store;
            stall  = !done;
            n_wait = dmem_gnt_i && !store;
        end else begin
            done   = 1;
            n_wait = 0;
        end

        check("dmem_req", dmem_req_o, req);
        check("stall", stall_o, stall);
        if (req) begin
            check("dmem_addr", dmem_addr_o, alu_res_i & ~32'h3);
            check("dmem_we", dmem_we_o, store);
            check("dmem_be", dmem_be_o, m_be(memop_type_i, alu_res_i));
            if (store) check("dmem_wdata", dmem_wdata_o, m_wdata(memop_type_i, rf_st_data_i));
        end
        check("rf_we", rf_we_o, e_we);
        check("misaligned", misaligned_o, e_mis);
        check("tkbr", tkbr_o, e_tk);
        if (e_we) begin
            check("rf_waddr", rf_waddr_o, e_waddr);
            check("rf_wdata", rf_wdata_o, e_wdata);
        end
        if (e_tk) check("new_pc", new_pc_o, e_pc);

        if (rsn_i) begin
            n_we = 0; n_mis = 0; n_tk = 0; n_wdata = 0; n_pc = 0; n_waddr = 0;
        end else begin
            n_we    = done && rf_we_i && !mis;
            n_mis   = mis && !m_wait;
            n_tk    = done && tkbr_i;
            n_waddr = rf_waddr_i;
            n_pc    = new_pc_i;
            n_wdata = memop_rd_i   ? m_load(memop_type_i, memop_sign_ext_i, alu_res_i, dmem_rdata_i) :
                      is_jaljalr_i ? seq_new_pc_i : alu_res_i;
        end
    end

    always @(posedge clk_i) begin
        m_wait  <= n_wait;
        e_we    <= n_we;
        e_mis   <= n_mis;
        e_tk    <= n_tk;
        e_wdata <= n_wdata;
        e_waddr <= n_waddr;
        e_pc    <= n_pc;
    end

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic nop();
        alu_res_i = 0; rf_we_i = 0; rf_waddr_i = 0; rf_st_data_i = 0; memop_type_i = WORD;
        memop_rd_i = 0; memop_wr_i = 0; memop_sign_ext_i = 0; tkbr_i = 0; new_pc_i = 0;
        seq_new_pc_i = 0; is_jaljalr_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    endtask

    task automatic set_op(input bit rd, input bit wr, input memop_data_type_e t, input bit sx,
                          input logic [31:0] addr, input logic [31:0] data);
        nop();
        memop_rd_i = rd; memop_wr_i = wr; memop_type_i = t; memop_sign_ext_i = sx;
        alu_res_i = addr; rf_st_data_i = data; rf_we_i = rd; rf_waddr_i = 5'd7;
    endtask

    // Presents one access, grants after gd idle cycles, returns load data after lat cycles.
    task automatic do_op(input bit rd, input bit wr, input memop_data_type_e t, input bit sx,
                         input logic [31:0] addr, input logic [31:0] data, input int gd,
                         input int lat, input logic [31:0] rdata, input logic [31:0] exp_wb);
        set_op(rd, wr, t, sx, addr, data);
        repeat (gd) cycle();
        dmem_gnt_i = 1;
        cycle();
        dmem_gnt_i = 0;
        if (rd) begin
            repeat (lat) cycle();
            dmem_rvalid_i = 1;
            dmem_rdata_i  = rdata;
            cycle();
        end
        nop();
        @(negedge clk_i);
        if (rd) begin
            check("op_wb_we", rf_we_o, 1);
            check("op_wb_data", rf_wdata_o, exp_wb);
        end
        cycle();
    endtask

    initial begin : watchdog
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : stim
        int stalls;
        nop();
        rsn_i = 1;
        repeat (2) cycle();
        @(negedge clk_i);
        check("rst_rf_we", rf_we_o, 0);
        check("rst_req", dmem_req_o, 0);
        check("rst_wdata", rf_wdata_o, 0);
        cycle();
        rsn_i = 0;
        cycle();

        // Byte store granted immediately.
        set_op(0, 1, BYTE, 0, 32'h103, 32'hAB);
        dmem_gnt_i = 1;
        @(negedge clk_i);
        check("sb_be", dmem_be_o, 4'b1000);
        check("sb_wdata", dmem_wdata_o, 32'hABABABAB);
        check("sb_stall", stall_o, 0);
        cycle();
        nop();
        cycle();

        // Sign-extended half load, one stall cycle.
        stalls = 0;
        set_op(1, 0, HALF, 1, 32'h202, 0);
        dmem_gnt_i = 1;
        @(negedge clk_i);
        stalls += int'(stall_o);
        cycle();
        dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h8001_1234;
        @(negedge clk_i);
        stalls += int'(stall_o);
        cycle();
        nop();
        @(negedge clk_i);
        check("lh_stalls", stalls, 1);
        check("lh_we", rf_we_o, 1);
        check("lh_wdata", rf_wdata_o, 32'hFFFF8001);
        cycle();

        // Word load with grant delayed three cycles.
        set_op(1, 0, WORD, 0, 32'h300, 0);
        for (int i = 0; i < 4; i++) begin
            dmem_gnt_i = (i == 3);
            @(negedge clk_i);
            check("lw_req_held", dmem_req_o, 1);
            check("lw_addr_held", dmem_addr_o, 32'h300);
            check("lw_stall", stall_o, 1);
            cycle();
        end
        dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        check("lw_no_dup_req", dmem_req_o, 0);
        check("lw_stall_end", stall_o, 0);
        cycle();
        nop();
        @(negedge clk_i);
        check("lw_wdata", rf_wdata_o, 32'hDEADBEEF);
        cycle();

        // Misaligned word load.
        set_op(1, 0, WORD, 0, 32'h6, 0);
        @(negedge clk_i);
        check("mis_req", dmem_req_o, 0);
        check("mis_stall", stall_o, 0);
        cycle();
        nop();
        @(negedge clk_i);
        check("mis_pulse", misaligned_o, 1);
        check("mis_we", rf_we_o, 0);
        cycle();
        @(negedge clk_i);
        check("mis_pulse_end", misaligned_o, 0);
        cycle();

        // JAL with taken redirect.
        nop();
        rf_we_i = 1; rf_waddr_i = 5'd1; is_jaljalr_i = 1; seq_new_pc_i = 32'h44;
        alu_res_i = 32'h1234; tkbr_i = 1; new_pc_i = 32'h80;
        cycle();
        nop();
        @(negedge clk_i);
        check("jal_wdata", rf_wdata_o, 32'h44);
        check("jal_tkbr", tkbr_o, 1);
        check("jal_pc", new_pc_o, 32'h80);
        cycle();

        // Table of further accesses.
        do_op(0, 1, HALF, 0, 32'h106, 32'h1234CAFE, 1, 0, 0, 0);
        do_op(1, 0, BYTE, 1, 32'h101, 0, 0, 2, 32'h11228344, 32'hFFFFFF83);
        do_op(1, 0, BYTE, 0, 32'h101, 0, 0, 0, 32'h11228344, 32'h00000083);
        do_op(1, 1, WORD, 0, 32'h200, 32'h99, 2, 0, 32'h55AA0FF0, 32'h55AA0FF0);
        do_op(0, 1, WORD, 0, 32'h10, 32'h01234567, 0, 0, 0, 0);
        do_op(1, 0, HALF, 0, 32'h0, 0, 1, 1, 32'h8001F00D, 32'h0000F00D);

        // Reset while waiting for load data; the late rvalid must be dropped.
        set_op(1, 0, WORD, 0, 32'h400, 0);
        dmem_gnt_i = 1;
        cycle();
        dmem_gnt_i = 0;
        rsn_i = 1;
        @(negedge clk_i);
        check("rstw_req", dmem_req_o, 0);
        cycle();
        rsn_i = 0;
        nop();
        dmem_rvalid_i = 1; dmem_rdata_i = 32'hBADBAD00;
        @(negedge clk_i);
        check("rstw_we", rf_we_o, 0);
        check("rstw_wdata", rf_wdata_o, 0);
        check("rstw_tkbr", tkbr_o, 0);
        check("rstw_mis", misaligned_o, 0);
        check("rstw_stall", stall_o, 0);
        cycle();
        nop();
        @(negedge clk_i);
        check("rstw_late_we", rf_we_o, 0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
